// File: rtl/core_wb_bridge.sv
// core_wb_bridge: core request/grant load-store port to a Wishbone classic master.
// Steers byte lanes, extends loads, traps misaligned accesses and times out stalled bus cycles.
module core_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter bit PIPELINED_ACK  = 1'b0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    req_i,
    input  logic                    wren_i,
    input  logic [1:0]              size_i,
    input  logic                    usgn_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);
    // state | meaning
    // IDLE  | waiting for a request, gnt_o follows req_i
    // BUS   | Wishbone cycle in flight, timeout counter running
    // RESP  | registered response stage (PIPELINED_ACK only)
    // TRAP  | misaligned request answered with an error, no bus cycle
    localparam int SEL_W   = DATA_WIDTH / 8;
    localparam int OFF_W   = $clog2(SEL_W);
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUS, RESP, TRAP} state_t;
    state_t state, state_nxt;

    logic [OFF_W-1:0]      off;
    logic [OFF_W-1:0]      off_q;
    logic [OFF_W-1:0]      align_mask;
    logic                  misaligned;
    logic [SEL_W-1:0]      sel_nxt;
    logic [SEL_W-1:0]      sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wren_q;
    logic                  usgn_q;
    logic [1:0]            size_q;
    logic [CNT_W-1:0]      cnt;
    logic                  timeout_hit;
    logic                  bus_done;
    logic                  bus_err;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] ext_mask;
    logic                  lane_sign;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign off = addr_i[OFF_W-1:0];

    always_comb begin
        case (size_i)
            2'b00:   align_mask = '0;
            2'b01:   align_mask = OFF_W'(1);
            2'b10:   align_mask = OFF_W'(3);
            default: align_mask = OFF_W'(7);
        endcase
    end

    assign misaligned = ((off & align_mask) != '0) || ((size_i == 2'b11) && (DATA_WIDTH == 32));
    assign sel_nxt    = SEL_W'(((32'd1 << (32'd1 << size_i)) - 32'd1) << off);

    // Load path: shift the addressed lane down, then mask and extend by access size.
    assign lane = wb_data_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00: begin
                ext_mask  = DATA_WIDTH'(8'hFF);
                lane_sign = lane[7];
            end
            2'b01: begin
                ext_mask  = DATA_WIDTH'(16'hFFFF);
                lane_sign = lane[15];
            end
            2'b10: begin
                ext_mask  = DATA_WIDTH'(32'hFFFF_FFFF);
                lane_sign = lane[31];
            end
            default: begin
                ext_mask  = '1;
                lane_sign = lane[DATA_WIDTH-1];
            end
        endcase
    end

    assign load_data = (lane & ext_mask) | ((lane_sign && !usgn_q) ? ~ext_mask : '0);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));
    assign bus_done    = wb_err_i | wb_ack_i | timeout_hit;
    // Only meaningful with bus_done: err beats ack, ack beats timeout.
    assign bus_err     = wb_err_i | ~wb_ack_i;
    assign resp_data   = (bus_err || wren_q) ? '0 : load_data;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_nxt = misaligned ? TRAP : BUS;
                end
            end
            BUS: begin
                if (bus_done) begin
                    state_nxt = PIPELINED_ACK ? RESP : IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            TRAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_o     = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_sel_o  = '0;
        wb_addr_o = '0;
        wb_data_o = '0;
        case (state)
            IDLE: gnt_o = req_i;
            BUS: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_we_o   = wren_q;
                wb_sel_o  = sel_q;
                wb_addr_o = addr_q;
                wb_data_o = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            wren_q      <= 1'b0;
            usgn_q      <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            cnt         <= '0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rvalid_q <= 1'b0;
            if (state == IDLE && req_i) begin
                wren_q  <= wren_i;
                usgn_q  <= usgn_i;
                size_q  <= size_i;
                off_q   <= off;
                addr_q  <= addr_i & ~ADDR_WIDTH'(SEL_W - 1);
                wdata_q <= wdata_i << {off, 3'b000};
                sel_q   <= sel_nxt;
                // Trap response is issued straight from the grant edge.
                if (misaligned) begin
                    rvalid_q <= 1'b1;
                    err_q    <= 1'b1;
                    rdata_q  <= '0;
                end
            end
            if (state == BUS) begin
                cnt <= cnt + CNT_W'(1);
                if (bus_done) begin
                    if (PIPELINED_ACK) begin
                        resp_err_q  <= bus_err;
                        resp_data_q <= resp_data;
                    end else begin
                        rvalid_q <= 1'b1;
                        err_q    <= bus_err;
                        rdata_q  <= resp_data;
                    end
                end
            end else begin
                cnt <= '0;
            end
            if (state == RESP) begin
                rvalid_q <= 1'b1;
                err_q    <= resp_err_q;
                rdata_q  <= resp_data_q;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
endmodule

// File: tb/tb_core_wb_bridge.sv
// Bench for core_wb_bridge: a 32-bit direct-response instance and a 64-bit pipelined instance,
// each checked against a byte-level reference model of lane steering, extension and timing.
module tb_core_wb_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_mis = 0;

    // Instance A: 32-bit, PIPELINED_ACK=0, TIMEOUT_CYCLES=4
    logic        a_req = 0, a_we = 0, a_usgn = 0, a_ack = 0, a_werr = 0;
    logic [1:0]  a_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_wbdi = 0;
    logic        a_gnt, a_rvalid, a_err, a_cyc, a_stb, a_wbwe;
    logic [31:0] a_rdata, a_wbaddr, a_wbdo;
    logic [3:0]  a_sel;

    // Instance B: 64-bit, PIPELINED_ACK=1, TIMEOUT_CYCLES=4
    logic        b_req = 0, b_we = 0, b_usgn = 0, b_ack = 0, b_werr = 0;
    logic [1:0]  b_size = 0;
    logic [31:0] b_addr = 0;
    logic [63:0] b_wdata = 0, b_wbdi = 0;
    logic        b_gnt, b_rvalid, b_err, b_cyc, b_stb, b_wbwe;
    logic [63:0] b_rdata, b_wbdo;
    logic [31:0] b_wbaddr;
    logic [7:0]  b_sel;

    core_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PIPELINED_ACK(1'b0), .TIMEOUT_CYCLES(4)) u_a (
        .clk_core(clk), .rst_core(rst), .req_i(a_req), .wren_i(a_we), .size_i(a_size),
        .usgn_i(a_usgn), .addr_i(a_addr), .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
        .err_o(a_err), .rdata_o(a_rdata), .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_we_o(a_wbwe),
        .wb_sel_o(a_sel), .wb_addr_o(a_wbaddr), .wb_data_o(a_wbdo), .wb_data_i(a_wbdi),
        .wb_ack_i(a_ack), .wb_err_i(a_werr));

    core_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .PIPELINED_ACK(1'b1), .TIMEOUT_CYCLES(4)) u_b (
        .clk_core(clk), .rst_core(rst), .req_i(b_req), .wren_i(b_we), .size_i(b_size),
        .usgn_i(b_usgn), .addr_i(b_addr), .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
        .err_o(b_err), .rdata_o(b_rdata), .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_wbwe),
        .wb_sel_o(b_sel), .wb_addr_o(b_wbaddr), .wb_data_o(b_wbdo), .wb_data_i(b_wbdi),
        .wb_ack_i(b_ack), .wb_err_i(b_werr));

    always @(negedge clk) begin
        if (!rst && ((a_cyc !== a_stb) || (b_cyc !== b_stb))) cyc_mis++;
    end

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic bit m_trap(input logic [31:0] ad, input logic [1:0] sz, input int nbus);
        int off;
        int nb;
        off = int'(ad % 32'(nbus));
        nb  = 1 << sz;
        return (nb > nbus) || ((off % nb) != 0);
    endfunction

    function automatic logic [63:0] m_sel(input logic [31:0] ad, input logic [1:0] sz, input int nbus);
        int off;
        int nb;
        off = int'(ad % 32'(nbus));
        nb  = 1 << sz;
        return ((64'd1 << nb) - 64'd1) << off;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [31:0] ad, input int nbus);
        logic [63:0] r;
        r = wd << (8 * int'(ad % 32'(nbus)));
        if (nbus == 4) r[63:32] = '0;
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] bus, input logic [31:0] ad,
                                           input logic [1:0] sz, input logic us, input int nbus);
        int off;
        int nb;
        logic [63:0] v;
        logic [63:0] mask;
        off  = int'(ad % 32'(nbus));
        nb   = 1 << sz;
        v    = bus >> (8 * off);
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!us && v[8 * nb - 1]) v = v | ~mask;
        if (nbus == 4) v[63:32] = '0;
        return v;
    endfunction

    // ---------------- drivers (report observations, scenarios compare) ----------------
    task automatic a_do(input logic we, input logic [1:0] sz, input logic us, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] bd, input int wt, input int kind,
                        output logic g, output int stb_n, output logic [3:0] sel, output logic [31:0] wa,
                        output logic [31:0] wdo, output logic wwe, output int lat, output logic e,
                        output logic [31:0] rd);
        @(negedge clk);
        a_req = 1; a_we = we; a_size = sz; a_usgn = us; a_addr = ad; a_wdata = wd; a_wbdi = bd;
        #1 g = a_gnt;
        @(negedge clk);
        a_req = 0;
        stb_n = 0; lat = -1; sel = '0; wa = '0; wdo = '0; wwe = 0; e = 0; rd = '0;
        for (int c = 0; c < 40; c++) begin
            if (a_rvalid) begin
                lat = c; e = a_err; rd = a_rdata;
                break;
            end
            if (a_stb) begin
                if (stb_n == 0) begin
                    sel = a_sel; wa = a_wbaddr; wdo = a_wbdo; wwe = a_wbwe;
                end
                if (stb_n == wt) begin
                    a_ack = (kind != 1); a_werr = (kind != 0);
                end
                stb_n++;
            end
            @(negedge clk);
            a_ack = 0; a_werr = 0;
        end
    endtask

    task automatic b_do(input logic we, input logic [1:0] sz, input logic us, input logic [31:0] ad,
                        input logic [63:0] wd, input logic [63:0] bd, input int wt, input int kind,
                        output logic g, output int stb_n, output logic [7:0] sel, output logic [31:0] wa,
                        output logic [63:0] wdo, output logic wwe, output int lat, output logic e,
                        output logic [63:0] rd);
        @(negedge clk);
        b_req = 1; b_we = we; b_size = sz; b_usgn = us; b_addr = ad; b_wdata = wd; b_wbdi = bd;
        #1 g = b_gnt;
        @(negedge clk);
        b_req = 0;
        stb_n = 0; lat = -1; sel = '0; wa = '0; wdo = '0; wwe = 0; e = 0; rd = '0;
        for (int c = 0; c < 40; c++) begin
            if (b_rvalid) begin
                lat = c; e = b_err; rd = b_rdata;
                break;
            end
            if (b_stb) begin
                if (stb_n == 0) begin
                    sel = b_sel; wa = b_wbaddr; wdo = b_wbdo; wwe = b_wbwe;
                end
                if (stb_n == wt) begin
                    b_ack = (kind != 1); b_werr = (kind != 0);
                end
                stb_n++;
            end
            @(negedge clk);
            b_ack = 0; b_werr = 0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({a_gnt, a_rvalid, a_err, a_rdata, a_cyc, a_stb, a_wbwe, a_sel, a_wbaddr, a_wbdo} !== '0) begin
            errors++; $display("FAIL reset_a: outputs not all zero (rdata=%h sel=%b)", a_rdata, a_sel);
        end
        checks++;
        if ({b_gnt, b_rvalid, b_err, b_rdata, b_cyc, b_stb, b_wbwe, b_sel, b_wbaddr, b_wbdo} !== '0) begin
            errors++; $display("FAIL reset_b: outputs not all zero (rdata=%h sel=%b)", b_rdata, b_sel);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({a_gnt, a_rvalid, a_cyc, b_gnt, b_rvalid, b_cyc} !== 6'b0) begin
            errors++; $display("FAIL idle_after_reset: gnt/rvalid/cyc got %b want 000000",
                               {a_gnt, a_rvalid, a_cyc, b_gnt, b_rvalid, b_cyc});
        end
    endtask

    task automatic test_byte_store();
        logic g, wwe, e; int n, lat; logic [3:0] sel; logic [31:0] wa, wdo, rd;
        a_do(1, 2'b00, 0, 32'h1003, 32'h0000_00A5, 32'h0, 1, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({g, sel, wa, wdo, wwe} !== {1'b1, 4'b1000, 32'h1000, 32'hA500_0000, 1'b1}) begin
            errors++; $display("FAIL byte_store_bus: got g=%b sel=%b addr=%h data=%h we=%b", g, sel, wa, wdo, wwe);
        end
        checks++;
        if ({n, lat, e, rd} !== {32'd2, 32'd2, 1'b0, 32'h0}) begin
            errors++; $display("FAIL byte_store_resp: got stb=%0d lat=%0d err=%b rdata=%h want 2 2 0 0", n, lat, e, rd);
        end
    endtask

    task automatic test_half_load();
        logic g, wwe, e; int n, lat; logic [3:0] sel; logic [31:0] wa, wdo, rd;
        a_do(0, 2'b01, 0, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({sel, wa, rd, e, lat} !== {4'b1100, 32'h2000, 32'hFFFF_8001, 1'b0, 32'd1}) begin
            errors++; $display("FAIL half_signed: got sel=%b addr=%h rdata=%h err=%b lat=%0d", sel, wa, rd, e, lat);
        end
        @(negedge clk);
        checks++;
        if ({a_rvalid, a_rdata} !== {1'b0, 32'hFFFF_8001}) begin
            errors++; $display("FAIL rvalid_pulse_hold: got rvalid=%b rdata=%h want 0 ffff8001", a_rvalid, a_rdata);
        end
        a_do(0, 2'b01, 1, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if (rd !== 32'h0000_8001) begin
            errors++; $display("FAIL half_unsigned: got %h want 00008001", rd);
        end
    endtask

    task automatic test_misaligned();
        logic g, wwe, e; int n, lat; logic [3:0] sel; logic [31:0] wa, wdo, rd;
        a_do(0, 2'b10, 0, 32'h0101, 32'h0, 32'hFFFF_FFFF, 0, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({g, n, lat, e, rd} !== {1'b1, 32'd0, 32'd0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL misaligned_word: got gnt=%b stb=%0d lat=%0d err=%b rdata=%h", g, n, lat, e, rd);
        end
        a_do(0, 2'b01, 0, 32'h0103, 32'h0, 32'hFFFF_FFFF, 0, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({g, n, lat, e} !== {1'b1, 32'd0, 32'd0, 1'b1}) begin
            errors++; $display("FAIL misaligned_half: got gnt=%b stb=%0d lat=%0d err=%b", g, n, lat, e);
        end
    endtask

    task automatic test_timeout();
        logic g, wwe, e; int n, lat, late_rv; logic [3:0] sel; logic [31:0] wa, wdo, rd;
        a_do(0, 2'b10, 0, 32'h3000, 32'h0, 32'h1234_5678, -1, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({n, lat, e, rd} !== {32'd4, 32'd4, 1'b1, 32'h0}) begin
            errors++; $display("FAIL timeout: got stb=%0d lat=%0d err=%b rdata=%h want 4 4 1 0", n, lat, e, rd);
        end
        late_rv = 0;
        a_ack = 1;
        repeat (3) begin
            @(negedge clk);
            if (a_rvalid) late_rv++;
        end
        a_ack = 0;
        checks++;
        if (late_rv !== 0) begin
            errors++; $display("FAIL late_ack: got %0d extra rvalid want 0", late_rv);
        end
        a_do(0, 2'b10, 0, 32'h3004, 32'h0, 32'h1234_5678, 0, 2, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({e, rd} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL ack_err_same: got err=%b rdata=%h want 1 0", e, rd);
        end
        a_do(0, 2'b10, 0, 32'h3008, 32'h0, 32'h1234_5678, 3, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({n, e, rd} !== {32'd4, 1'b0, 32'h1234_5678}) begin
            errors++; $display("FAIL ack_in_timeout_cycle: got stb=%0d err=%b rdata=%h", n, e, rd);
        end
    endtask

    task automatic test_random_a();
        logic g, wwe, e, we, us; int n, lat, wt, kind; logic [1:0] sz;
        logic [3:0] sel; logic [31:0] wa, wdo, rd, ad, wd, bd;
        logic [63:0] esel, ewd, eld;
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(0, 2)); ad = $urandom; wd = $urandom; bd = $urandom;
            we = 1'($urandom_range(0, 1)); us = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 3); kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
            a_do(we, sz, us, ad, wd, bd, wt, kind, g, n, sel, wa, wdo, wwe, lat, e, rd);
            esel = m_sel(ad, sz, 4); ewd = m_wdata({32'h0, wd}, ad, 4); eld = m_load({32'h0, bd}, ad, sz, us, 4);
            checks++;
            if (m_trap(ad, sz, 4)) begin
                if ({g, n, lat, e, rd} !== {1'b1, 32'd0, 32'd0, 1'b1, 32'h0}) begin
                    errors++; $display("FAIL rand_a_trap[%0d]: got gnt=%b stb=%0d lat=%0d err=%b", i, g, n, lat, e);
                end
            end else begin
                if ({g, sel, wa, wdo, wwe, n, lat, e, rd} !==
                    {1'b1, esel[3:0], ad & 32'hFFFF_FFFC, ewd[31:0], we, wt + 1, wt + 1, kind != 0,
                     (kind != 0 || we) ? 32'h0 : eld[31:0]}) begin
                    errors++; $display("FAIL rand_a[%0d]: got sel=%b addr=%h data=%h stb=%0d lat=%0d err=%b rdata=%h want rdata=%h",
                                       i, sel, wa, wdo, n, lat, e, rd, eld[31:0]);
                end
            end
        end
    endtask

    task automatic test_pipelined();
        logic g, wwe, e; int n, lat; logic [7:0] sel; logic [31:0] wa; logic [63:0] wdo, rd;
        b_do(0, 2'b11, 0, 32'h8, 64'h0, 64'h8877_6655_4433_2211, 0, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({g, sel, wa, n, lat, e, rd} !== {1'b1, 8'hFF, 32'h8, 32'd1, 32'd2, 1'b0, 64'h8877_6655_4433_2211}) begin
            errors++; $display("FAIL pipe_dword: got sel=%h addr=%h stb=%0d lat=%0d err=%b rdata=%h", sel, wa, n, lat, e, rd);
        end
        b_do(0, 2'b10, 0, 32'hC, 64'h0, 64'h8877_6655_4433_2211, 0, 0, g, n, sel, wa, wdo, wwe, lat, e, rd);
        checks++;
        if ({sel, wa, rd} !== {8'hF0, 32'h8, 64'hFFFF_FFFF_8877_6655}) begin
            errors++; $display("FAIL pipe_word_hi: got sel=%h addr=%h rdata=%h", sel, wa, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ads[3] = '{32'h100, 32'h204, 32'h30B};
        logic [1:0]  szs[3] = '{2'b10, 2'b01, 2'b00};
        logic        uss[3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] exp_q[$];
        logic [63:0] want;
        int ngr = 0, nrv = 0, t_done = -1, bad = 0;
        @(negedge clk);
        for (int c = 0; c < 30 && nrv < 3; c++) begin
            if (b_rvalid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                if (b_rdata !== want || b_err !== 1'b0) bad++;
                nrv++;
                if (nrv == 3) t_done = c;
            end
            if (b_stb && ngr > 0) begin
                b_wbdi = {$urandom, $urandom}; b_ack = 1;
                exp_q.push_back(m_load(b_wbdi, ads[ngr-1], szs[ngr-1], uss[ngr-1], 8));
            end else begin
                b_ack = 0;
            end
            b_req = (ngr < 3);
            if (ngr < 3) begin
                b_we = 0; b_addr = ads[ngr]; b_size = szs[ngr]; b_usgn = uss[ngr];
            end
            #1 if (b_gnt) ngr++;
            @(negedge clk);
        end
        b_req = 0; b_ack = 0;
        checks++;
        if ({t_done, ngr, bad} !== {32'd9, 32'd3, 32'd0}) begin
            errors++; $display("FAIL back_to_back: got done_cycle=%0d grants=%0d bad_data=%0d want 9 3 0", t_done, ngr, bad);
        end
    endtask

    task automatic test_random_b();
        logic g, wwe, e, we, us; int n, lat, wt, kind; logic [1:0] sz;
        logic [7:0] sel; logic [31:0] wa, ad; logic [63:0] wdo, rd, wd, bd, esel, ewd, eld;
        for (int i = 0; i < 16; i++) begin
            sz = 2'($urandom_range(0, 3)); ad = $urandom; wd = {$urandom, $urandom}; bd = {$urandom, $urandom};
            we = 1'($urandom_range(0, 1)); us = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 2); kind = ($urandom_range(0, 4) == 0) ? 2 : 0;
            b_do(we, sz, us, ad, wd, bd, wt, kind, g, n, sel, wa, wdo, wwe, lat, e, rd);
            esel = m_sel(ad, sz, 8); ewd = m_wdata(wd, ad, 8); eld = m_load(bd, ad, sz, us, 8);
            checks++;
            if (m_trap(ad, sz, 8)) begin
                if ({g, n, lat, e, rd} !== {1'b1, 32'd0, 32'd0, 1'b1, 64'h0}) begin
                    errors++; $display("FAIL rand_b_trap[%0d]: got gnt=%b stb=%0d lat=%0d err=%b", i, g, n, lat, e);
                end
            end else begin
                if ({g, sel, wa, wdo, wwe, n, lat, e, rd} !==
                    {1'b1, esel[7:0], ad & 32'hFFFF_FFF8, ewd, we, wt + 1, wt + 2, kind != 0,
                     (kind != 0 || we) ? 64'h0 : eld}) begin
                    errors++; $display("FAIL rand_b[%0d]: got sel=%h addr=%h stb=%0d lat=%0d err=%b rdata=%h want rdata=%h",
                                       i, sel, wa, n, lat, e, rd, eld);
                end
            end
        end
    endtask

    task automatic test_reset_bus();
        logic g, s1; int rv;
        @(negedge clk);
        a_req = 1; a_we = 0; a_size = 2'b10; a_usgn = 0; a_addr = 32'h4000; a_wbdi = 32'h0BAD_F00D;
        #1 g = a_gnt;
        @(negedge clk);
        a_req = 0; s1 = a_stb;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        checks++;
        if ({g, s1, a_cyc, a_stb, a_rvalid} !== 5'b11000) begin
            errors++; $display("FAIL reset_in_bus: got gnt=%b stb1=%b cyc=%b stb=%b rvalid=%b want 1 1 0 0 0",
                               g, s1, a_cyc, a_stb, a_rvalid);
        end
        rst = 0;
        @(negedge clk);
        rv = a_rvalid ? 1 : 0;
        a_req = 1; a_addr = 32'h4004; a_wbdi = 32'h1357_9BDF;
        #1 g = a_gnt;
        @(negedge clk);
        a_req = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_rvalid) break;
            a_ack = a_stb;
            @(negedge clk);
            a_ack = 0;
        end
        checks++;
        if ({rv, g, a_rvalid, a_err, a_rdata} !== {32'd0, 1'b1, 1'b1, 1'b0, 32'h1357_9BDF}) begin
            errors++; $display("FAIL grant_after_reset: got stray_rv=%0d gnt=%b rvalid=%b err=%b rdata=%h",
                               rv, g, a_rvalid, a_err, a_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_half_load();
        test_misaligned();
        test_timeout();
        test_random_a();
        test_pipelined();
        test_back_to_back();
        test_random_b();
        test_reset_bus();
        checks++;
        if (cyc_mis !== 0) begin
            errors++; $display("FAIL cyc_stb_pair: got %0d cycles with cyc!=stb want 0", cyc_mis);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/core_wb_bridge.md
# core_wb_bridge

Parametrised bridge between a core's request/grant load-store port and a Wishbone classic master interface. It supersedes the per-core glue in `processorci_top` that wires instruction and data ports to `core_*` / `data_mem_*`. It adds:
- size-aware lane steering and byte-select generation;
- load sign/zero extension;
- misalignment trapping;
- a bus timeout;
- an optional registered response stage that replaces the `PIPELINED_WISHBONE` define.

One instance is used per memory port.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, core and bus address width.
- `DATA_WIDTH`, 32, bus data width; legal values are 32 and 64.
- `PIPELINED_ACK`, 0, when 1, inserts one response register stage.
- `TIMEOUT_CYCLES`, 255, maximum bus-cycle length before an error response; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk_core` in 1: core clock; all logic is on the rising edge.
- `rst_core` in 1: synchronous active-high reset.
- `req_i` in 1: core request.
- `wren_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = dword (dword only legal when `DATA_WIDTH`=64).
- `usgn_i` in 1: 1 = zero-extend loads, 0 = sign-extend loads.
- `addr_i` in `ADDR_WIDTH`: byte address.
- `wdata_i` in `DATA_WIDTH`: store data, right-aligned.
- `gnt_o` out 1: request accepted this cycle.
- `rvalid_o` out 1: one-cycle response strobe.
- `err_o` out 1: error qualifier; valid when `rvalid_o`=1.
- `rdata_o` out `DATA_WIDTH`: extended load data.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_stb_o` out 1: Wishbone strobe.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_sel_o` out `DATA_WIDTH`/8: byte selects.
- `wb_addr_o` out `ADDR_WIDTH`: word-aligned bus address.
- `wb_data_o` out `DATA_WIDTH`: lane-steered write data.
- `wb_data_i` in `DATA_WIDTH`: bus read data.
- `wb_ack_i` in 1: bus acknowledge.
- `wb_err_i` in 1: bus error.

## Operation
**States.** IDLE, BUS, RESP (RESP is only used when `PIPELINED_ACK`=1), TRAP.

**IDLE.** `gnt_o` = `req_i` (combinational, IDLE only). On a grant the request is registered; define `off` = `addr_i` mod (`DATA_WIDTH`/8).
- Misaligned request (`off` not a multiple of 2^`size_i`, or `size_i`=11 with `DATA_WIDTH`=32): go to TRAP. No bus cycle is issued.
- Otherwise: go to BUS.

**BUS.**
- Outputs: `wb_cyc_o` = `wb_stb_o` = 1, `wb_we_o` = stored `wren_i`.
- `wb_addr_o` = address with the low log2(`DATA_WIDTH`/8) bits cleared.
- `wb_sel_o` = ((1<<2^size)-1) << `off`.
- `wb_data_o` = `wdata_i` << (8·`off`).
- The timeout counter increments each BUS cycle.

**BUS exit condition**, in priority order:
1. `wb_err_i` → error response.
2. `wb_ack_i` → OK response.
3. counter = `TIMEOUT_CYCLES` (when nonzero) → error response.

On exit: go to IDLE (`PIPELINED_ACK`=0) or RESP (`PIPELINED_ACK`=1).

**RESP.** Presents the registered response, then returns to IDLE.

**TRAP.** Presents the error response, then returns to IDLE.

**Load data.** Take lane bits (8·`off`) upward, 2^size bytes wide. Sign- or zero-extend per `usgn_i` to `DATA_WIDTH`.

**Responses.** Stores, errors and traps return `rdata_o` = 0. `rdata_o` and `err_o` hold their value until the next response.

**Ignored inputs.**
- `wb_ack_i` and `wb_err_i` are ignored outside BUS.
- `req_i` is ignored outside IDLE (`gnt_o`=0).

**Reset.** All outputs reset to 0, state to IDLE, counter to 0. A reset during BUS drops `wb_cyc_o`/`wb_stb_o` at the next edge and produces no response.

## Timing
- Grant in cycle T.
- `wb_cyc_o`/`wb_stb_o` rise at T+1 and stay high through the ack cycle A.
- `wb_cyc_o`/`wb_stb_o` are low at A+1.
- `rvalid_o` = 1 at A+1 (`PIPELINED_ACK`=0) or A+2 (`PIPELINED_ACK`=1); it is a single-cycle pulse.
- Back-to-back throughput: next grant possible in the `rvalid_o` cycle. A zero-wait slave gives 2 cycles per access in mode 0 and 3 in mode 1.
- Timeout: the stb-high cycles equal `TIMEOUT_CYCLES` exactly; `rvalid_o`/`err_o` follow with the same latency as an ack.
- Misaligned: `rvalid_o`=`err_o`=1 at T+1 in both modes; `wb_cyc_o` never asserts.
- Ack and err in the same cycle: err wins. Ack in the timeout cycle: ack wins.

## Test plan
- **Byte store** (`DATA_WIDTH`=32): store byte to addr 0x1003, `wdata_i`=0xA5. Expect `wb_sel_o`=4'b1000, `wb_data_o`=0xA500_0000, `wb_addr_o`=0x1000. Ack at T+2 → `rvalid_o`=1, `err_o`=0 at T+3.
- **Half load, signed and unsigned**: load half from 0x2002 with `wb_data_i`=0x8001_1234. Expect `rdata_o`=0xFFFF_8001 for signed, 0x0000_8001 with `usgn_i`=1. Also expect `wb_sel_o`=4'b1100.
- **Misaligned word**: load word at 0x0101. Expect `gnt_o` at T, `rvalid_o`=`err_o`=1 at T+1, `wb_cyc_o`=0 throughout. A half load at 0x0103 also traps.
- **Timeout** (`TIMEOUT_CYCLES`=4), no ack: expect `wb_stb_o` high for exactly 4 cycles, then `rvalid_o`/`err_o`=1. A late `wb_ack_i` must produce no further `rvalid_o`. Then issue ack and err together on a fresh access and expect `err_o`=1.
- **Pipelined mode** (`PIPELINED_ACK`=1), zero-wait slave: expect `rvalid_o` at A+2. Three back-to-back loads complete in 9 cycles with correct data. With `DATA_WIDTH`=64, a dword load at 0x8 gives `wb_sel_o`=8'hFF.
- **Reset during BUS**: assert `rst_core` in cycle T+2. Expect `wb_cyc_o`=0 at T+3, no `rvalid_o`, state IDLE. A new request is granted immediately after reset is released.
